// File: rtl/wb_pkg.sv
// Shared widths and the write-request record used by the writeback arbiter.
// Optional forwarding ports are enabled in the top with WB_BYPASS_EN.
package wb_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    // "reg" is a keyword, so the destination field is wreg
    typedef struct packed {
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO holding pending secondary (load/multiply) results.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  wb_req_t       push_data,
    input  logic          pop,
    output wb_req_t       pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback: ALU has priority, memory results queue in wb_fifo.
// Define WB_BYPASS_EN to add write-port forwarding outputs that mask the decode hazard.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [REG_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_W-1:0]        mem_reg,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    issue_valid,
    input  logic [REG_W-1:0]        issue_reg,
    input  logic [REG_W-1:0]        RegRead_1,
    input  logic [REG_W-1:0]        RegRead_2,
    output logic                    hazard,
    output logic                    RegWrite,
    output logic [REG_W-1:0]        w_reg,
    output logic [DATA_W-1:0]       w_data,
`ifdef WB_BYPASS_EN
    output logic                    fwd_valid1,
    output logic                    fwd_valid2,
    output logic [DATA_W-1:0]       fwd_data1,
    output logic [DATA_W-1:0]       fwd_data2,
`endif
    output logic [$clog2(DEPTH):0]  fifo_count
);
    logic            alu_sel;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    wb_req_t         mem_req;
    wb_req_t         head;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    assign alu_sel   = alu_valid && (alu_reg != '0);
    assign mem_ready = reset && !full;
    // Register-0 results are handshaken but never queued
    assign push      = mem_valid && mem_ready && (mem_reg != '0);
    assign pop       = !alu_sel && !empty;
    assign mem_req   = '{wreg: mem_reg, data: mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mem_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWrite <= 1'b0;
            w_reg    <= '0;
            w_data   <= '0;
        end else if (alu_sel) begin
            RegWrite <= 1'b1;
            w_reg    <= alu_reg;
            w_data   <= alu_data;
        end else if (pop) begin
            RegWrite <= 1'b1;
            w_reg    <= head.wreg;
            w_data   <= head.data;
        end else begin
            RegWrite <= 1'b0;
        end
    end

    // Set is applied after clear so a same-edge issue to the retiring register wins
    always_comb begin
        pending_next = pending;
        if (RegWrite)    pending_next[w_reg]     = 1'b0;
        if (issue_valid) pending_next[issue_reg] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) pending <= '0;
        else        pending <= pending_next;
    end

`ifdef WB_BYPASS_EN
    assign fwd_valid1 = RegWrite && (w_reg == RegRead_1) && (RegRead_1 != '0);
    assign fwd_valid2 = RegWrite && (w_reg == RegRead_2) && (RegRead_2 != '0);
    assign fwd_data1  = w_data;
    assign fwd_data2  = w_data;
    assign hazard     = (pending[RegRead_1] && !fwd_valid1) ||
                        (pending[RegRead_2] && !fwd_valid2);
`else
    assign hazard     = pending[RegRead_1] || pending[RegRead_2];
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter against a queue-based reference model.
// Forwarding checks are included when WB_BYPASS_EN is defined.
module tb_writeback_arbiter;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [4:0]  RegRead_1;
    logic [4:0]  RegRead_2;
    logic        hazard;
    logic        RegWrite;
    logic [4:0]  w_reg;
    logic [31:0] w_data;
    logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
    logic        fwd_valid1;
    logic        fwd_valid2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [36:0] q[$];
    bit   [31:0] pend;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .RegRead_1   (RegRead_1),
        .RegRead_2   (RegRead_2),
        .hazard      (hazard),
        .RegWrite    (RegWrite),
        .w_reg       (w_reg),
        .w_data      (w_data),
`ifdef WB_BYPASS_EN
        .fwd_valid1  (fwd_valid1),
        .fwd_valid2  (fwd_valid2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2),
`endif
        .fifo_count  (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_hazard();
        logic h1;
        logic h2;
        h1 = pend[RegRead_1];
        h2 = pend[RegRead_2];
`ifdef WB_BYPASS_EN
        if (exp_we && exp_reg == RegRead_1 && RegRead_1 != 0) h1 = 1'b0;
        if (exp_we && exp_reg == RegRead_2 && RegRead_2 != 0) h2 = 1'b0;
`endif
        return h1 | h2;
    endfunction

    // Advance the model by one edge from the current inputs, then clock the DUT
    task automatic tick();
        logic [36:0] e;
        logic        rdy;
        if (!reset) begin
            q.delete();
            pend     = '0;
            exp_we   = 1'b0;
            exp_reg  = '0;
            exp_data = '0;
        end else begin
            assert (!(issue_valid && issue_reg != 0 && pend[issue_reg] &&
                      !(exp_we && exp_reg == issue_reg)))
                else $error("illegal issue to pending register %0d", issue_reg);
            rdy = (q.size() < DEPTH);
            if (exp_we) pend[exp_reg] = 1'b0;
            if (issue_valid && issue_reg != 0) pend[issue_reg] = 1'b1;
            if (alu_valid && alu_reg != 0) begin
                exp_we = 1'b1; exp_reg = alu_reg; exp_data = alu_data;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                exp_we = 1'b1; exp_reg = e[36:32]; exp_data = e[31:0];
            end else begin
                exp_we = 1'b0;
            end
            if (rdy && mem_valid && mem_reg != 0) q.push_back({mem_reg, mem_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        mem_valid = 0; mem_reg = 0; mem_data = 0;
        issue_valid = 0; issue_reg = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        alu_valid = 1; alu_reg = 9; alu_data = 32'h1234;
        mem_valid = 1; mem_reg = 8; mem_data = 32'h5678;
        issue_valid = 1; issue_reg = 6; RegRead_1 = 6; RegRead_2 = 8;
        tick();
        tick();
        checks++; if (RegWrite !== 1'b0) begin $display("FAIL reset_regwrite: got %b want 0", RegWrite); errors++; end
        checks++; if (w_reg !== 5'd0) begin $display("FAIL reset_w_reg: got %0d want 0", w_reg); errors++; end
        checks++; if (w_data !== 32'd0) begin $display("FAIL reset_w_data: got %h want 0", w_data); errors++; end
        checks++; if (fifo_count !== 3'd0) begin $display("FAIL reset_count: got %0d want 0", fifo_count); errors++; end
        checks++; if (mem_ready !== 1'b0) begin $display("FAIL reset_mem_ready: got %b want 0", mem_ready); errors++; end
        checks++; if (hazard !== 1'b0) begin $display("FAIL reset_hazard: got %b want 0", hazard); errors++; end
        idle_inputs();
        reset = 1;
        #1;
        checks++; if (mem_ready !== 1'b1) begin $display("FAIL release_mem_ready: got %b want 1", mem_ready); errors++; end
    endtask

    task automatic test_alu_only();
        alu_valid = 1; alu_reg = 5; alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        checks++; if (RegWrite !== 1'b1) begin $display("FAIL alu_regwrite: got %b want 1", RegWrite); errors++; end
        checks++; if (w_reg !== 5'd5) begin $display("FAIL alu_w_reg: got %0d want 5", w_reg); errors++; end
        checks++; if (w_data !== 32'hDEADBEEF) begin $display("FAIL alu_w_data: got %h want deadbeef", w_data); errors++; end
        tick();
        checks++; if (RegWrite !== 1'b0) begin $display("FAIL alu_idle: got %b want 0", RegWrite); errors++; end
    endtask

    task automatic test_contention();
        alu_valid = 1; alu_reg = 3; alu_data = 32'hA3A3A3A3;
        mem_valid = 1; mem_reg = 4; mem_data = 32'hB4B4B4B4;
        #1;
        checks++; if (mem_ready !== 1'b1) begin $display("FAIL cont_ready: got %b want 1", mem_ready); errors++; end
        tick();
        idle_inputs();
        checks++; if (RegWrite !== 1'b1 || w_reg !== 5'd3 || w_data !== 32'hA3A3A3A3) begin
            $display("FAIL cont_first: got we=%b reg=%0d data=%h want we=1 reg=3 data=a3a3a3a3", RegWrite, w_reg, w_data); errors++; end
        checks++; if (fifo_count !== 3'd1) begin $display("FAIL cont_count: got %0d want 1", fifo_count); errors++; end
        tick();
        checks++; if (RegWrite !== 1'b1 || w_reg !== 5'd4 || w_data !== 32'hB4B4B4B4) begin
            $display("FAIL cont_second: got we=%b reg=%0d data=%h want we=1 reg=4 data=b4b4b4b4", RegWrite, w_reg, w_data); errors++; end
        checks++; if (fifo_count !== 3'd0) begin $display("FAIL cont_drained: got %0d want 0", fifo_count); errors++; end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int k = 0;
        logic acc;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_reg = 5'(10 + i); alu_data = $urandom;
            mem_valid = (sent < 5); mem_reg = 5'(20 + sent); mem_data = $urandom;
            #1;
            if (i >= 4) begin
                checks++; if (mem_ready !== 1'b0 || fifo_count !== 3'd4) begin
                    $display("FAIL bp_full c%0d: got ready=%b count=%0d want ready=0 count=4", i, mem_ready, fifo_count); errors++; end
            end else begin
                checks++; if (mem_ready !== 1'b1 || fifo_count !== 3'(i)) begin
                    $display("FAIL bp_fill c%0d: got ready=%b count=%0d want ready=1 count=%0d", i, mem_ready, fifo_count, i); errors++; end
            end
            acc = mem_valid && (q.size() < DEPTH);
            tick();
            if (acc) sent++;
            checks++; if (RegWrite !== 1'b1 || w_reg !== 5'(10 + i)) begin
                $display("FAIL bp_alu c%0d: got we=%b reg=%0d want we=1 reg=%0d", i, RegWrite, w_reg, 10 + i); errors++; end
        end
        alu_valid = 0; alu_reg = 0;
        #1;
        checks++; if (mem_ready !== 1'b0) begin $display("FAIL bp_full_pop: got ready=%b want 0", mem_ready); errors++; end
        for (int c = 0; c < 12 && k < 5; c++) begin
            mem_valid = (sent < 5); mem_reg = 5'(20 + sent); mem_data = $urandom;
            acc = mem_valid && (q.size() < DEPTH);
            tick();
            if (acc) sent++;
            mem_valid = 0;
            checks++; if (RegWrite !== exp_we) begin $display("FAIL bp_drain_we: got %b want %b", RegWrite, exp_we); errors++; end
            if (exp_we) begin
                checks++; if (w_reg !== 5'(20 + k) || w_data !== exp_data) begin
                    $display("FAIL bp_order: got reg=%0d data=%h want reg=%0d data=%h", w_reg, w_data, 20 + k, exp_data); errors++; end
                k++;
            end
        end
        checks++; if (k != 5) begin $display("FAIL bp_drain_total: got %0d want 5", k); errors++; end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        RegRead_1 = 7; RegRead_2 = 0;
        issue_valid = 1; issue_reg = 7;
        tick();
        issue_valid = 0; issue_reg = 0;
        #1;
        checks++; if (hazard !== 1'b1) begin $display("FAIL sb_issued: got %b want 1", hazard); errors++; end
        mem_valid = 1; mem_reg = 7; mem_data = 32'h77777777;
        tick();
        mem_valid = 0;
        #1;
        checks++; if (hazard !== 1'b1) begin $display("FAIL sb_queued: got %b want 1", hazard); errors++; end
        tick();
        checks++; if (RegWrite !== 1'b1 || w_reg !== 5'd7) begin $display("FAIL sb_write: got we=%b reg=%0d want we=1 reg=7", RegWrite, w_reg); errors++; end
`ifdef WB_BYPASS_EN
        checks++; if (hazard !== 1'b0 || fwd_valid1 !== 1'b1 || fwd_data1 !== 32'h77777777) begin
            $display("FAIL sb_bypass: got hz=%b fv=%b fd=%h want hz=0 fv=1 fd=77777777", hazard, fwd_valid1, fwd_data1); errors++; end
`else
        checks++; if (hazard !== 1'b1) begin $display("FAIL sb_write_cycle: got %b want 1", hazard); errors++; end
`endif
        tick();
        checks++; if (hazard !== 1'b0) begin $display("FAIL sb_cleared: got %b want 0", hazard); errors++; end
    endtask

    task automatic test_reg0();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_reg = 0; alu_data = $urandom;
            mem_valid = 1; mem_reg = 0; mem_data = $urandom;
            #1;
            checks++; if (mem_ready !== 1'b1) begin $display("FAIL r0_ready: got %b want 1", mem_ready); errors++; end
            tick();
            checks++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin
                $display("FAIL r0_write: got we=%b count=%0d want we=0 count=0", RegWrite, fifo_count); errors++; end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_reg = 1; alu_data = $urandom;
            mem_valid = 1; mem_reg = 5'(9 + i); mem_data = $urandom;
            issue_valid = (i < 2); issue_reg = (i == 0) ? 5'd3 : 5'd7;
            tick();
        end
        idle_inputs();
        RegRead_1 = 3; RegRead_2 = 7;
        #1;
        checks++; if (fifo_count !== 3'd3 || hazard !== 1'b1) begin
            $display("FAIL mid_setup: got count=%0d hz=%b want count=3 hz=1", fifo_count, hazard); errors++; end
        reset = 0; mem_valid = 1; mem_reg = 12;
        tick();
        checks++; if (fifo_count !== 3'd0 || RegWrite !== 1'b0 || hazard !== 1'b0) begin
            $display("FAIL mid_reset: got count=%0d we=%b hz=%b want 0 0 0", fifo_count, RegWrite, hazard); errors++; end
        reset = 1; mem_valid = 0;
        tick();
        checks++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin
            $display("FAIL mid_after: got we=%b count=%0d want 0 0", RegWrite, fifo_count); errors++; end
    endtask

    task automatic test_random();
        logic [4:0] r;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            alu_valid = $urandom_range(0, 2) == 0; alu_reg = 5'($urandom_range(0, 31)); alu_data = $urandom;
            mem_valid = $urandom_range(0, 1); mem_reg = 5'($urandom_range(0, 31)); mem_data = $urandom;
            r = 5'($urandom_range(1, 31));
            issue_valid = ($urandom_range(0, 3) == 0) && !pend[r]; issue_reg = r;
            RegRead_1 = 5'($urandom_range(0, 31)); RegRead_2 = 5'($urandom_range(0, 31));
            #1;
            checks++; if (mem_ready !== (reset && q.size() < DEPTH)) begin
                $display("FAIL rnd_ready c%0d: got %b want %b", i, mem_ready, reset && q.size() < DEPTH); errors++; end
            checks++; if (fifo_count !== 3'(q.size())) begin
                $display("FAIL rnd_count c%0d: got %0d want %0d", i, fifo_count, q.size()); errors++; end
            checks++; if (hazard !== model_hazard()) begin
                $display("FAIL rnd_hazard c%0d: got %b want %b", i, hazard, model_hazard()); errors++; end
`ifdef WB_BYPASS_EN
            checks++; if (fwd_valid1 !== (exp_we && exp_reg == RegRead_1 && RegRead_1 != 0)) begin
                $display("FAIL rnd_fwd1 c%0d: got %b", i, fwd_valid1); errors++; end
`endif
            tick();
            checks++; if (RegWrite !== exp_we) begin
                $display("FAIL rnd_we c%0d: got %b want %b", i, RegWrite, exp_we); errors++; end
            if (exp_we) begin
                checks++; if (w_reg !== exp_reg || w_data !== exp_data) begin
                    $display("FAIL rnd_wport c%0d: got reg=%0d data=%h want reg=%0d data=%h", i, w_reg, w_data, exp_reg, exp_data); errors++; end
            end
        end
        reset = 1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 0; RegRead_1 = 0; RegRead_2 = 0;
        pend = '0; exp_we = 0; exp_reg = 0; exp_data = 0;
        test_reset();
        test_alu_only();
        test_contention();
        test_backpressure();
        test_scoreboard();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
